render_frame_ctrl: RTL and testbench

- Per-frame sequencer in front of ray_core and ray_caster.
- Holds a shadow material table written by the host. On start, it uploads the dirty entries into the core L2, then issues the L2->L1 flush. After a settle delay it latches the camera and pulses render_start.
- It counts output pixels until the frame is complete and reports frame_done.
- All vectors are 3 x 32-bit Q8.24 fixed point: x in [31:0], y in [63:32], z in [95:64].

---
 rtl/render_frame_ctrl_if.sv | 43 ++++
 rtl/render_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_render_frame_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/render_frame_ctrl_if.sv
// Controller-facing bundle: host table writes, camera inputs, ray_core/ray_caster strobes and status.
interface render_frame_ctrl_if;
  logic         start;
  logic         abort;
  logic         mat_wr_en;
  logic [2:0]   mat_wr_id;
  logic [288:0] mat_wr_data;
  logic [95:0]  cam_origin_in;
  logic [95:0]  cam_front_in;
  logic [95:0]  cam_left_in;
  logic [95:0]  cam_up_in;
  logic         core_output_valid;
  logic         l2_write_enable;
  logic [2:0]   l2_write_id;
  logic [288:0] l2_write_material;
  logic         l2_flush_to_l1;
  logic         render_start;
  logic [95:0]  camera_origin;
  logic [95:0]  camera_front;
  logic [95:0]  camera_left;
  logic [95:0]  camera_up;
  logic         busy;
  logic         frame_done;
  logic [19:0]  pixel_count;
  logic         mat_wr_drop;
  logic         timeout;

  modport master (
    input  start, abort, mat_wr_en, mat_wr_id, mat_wr_data,
    input  cam_origin_in, cam_front_in, cam_left_in, cam_up_in, core_output_valid,
    output l2_write_enable, l2_write_id, l2_write_material, l2_flush_to_l1, render_start,
    output camera_origin, camera_front, camera_left, camera_up,
    output busy, frame_done, pixel_count, mat_wr_drop, timeout
  );

  modport slave (
    output start, abort, mat_wr_en, mat_wr_id, mat_wr_data,
    output cam_origin_in, cam_front_in, cam_left_in, cam_up_in, core_output_valid,
    input  l2_write_enable, l2_write_id, l2_write_material, l2_flush_to_l1, render_start,
    input  camera_origin, camera_front, camera_left, camera_up,
    input  busy, frame_done, pixel_count, mat_wr_drop, timeout
  );
endinterface

// File: rtl/render_frame_ctrl.sv
// Per-frame sequencer: dirty material upload, L1 flush, settle, render_start, pixel count to frame_done.
// Optional RUN watchdog built when FRAME_TIMEOUT_EN is defined; otherwise timeout is tied low.
module render_frame_ctrl #(
  parameter int IMG_W         = 640,
  parameter int IMG_H         = 480,
  parameter int NUM_MATERIALS = 8,
  parameter int FLUSH_WAIT    = 4,
  parameter int TIMEOUT       = 65536
) (
  input logic clk,
  input logic rst,
  render_frame_ctrl_if.master bus
);
  localparam logic [19:0] PIX_TOTAL   = 20'(IMG_W * IMG_H);
  localparam logic [2:0]  LAST_ID     = 3'(NUM_MATERIALS - 1);
  localparam logic [3:0]  NUM_IDS     = 4'(NUM_MATERIALS);
  localparam logic [15:0] SETTLE_LAST = 16'(FLUSH_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_SETTLE, S_START, S_RUN, S_DONE
  } state_t;

  state_t                   state;
  logic [2:0]               scan_id;
  logic [2:0]               next_id;
  logic [15:0]              settle_cnt;
  logic [288:0]             mat_table [NUM_MATERIALS];
  logic [NUM_MATERIALS-1:0] dirty;
`ifdef FRAME_TIMEOUT_EN
  logic [31:0]              wd_cnt;
`endif

  assign next_id = scan_id + 3'd1;

`ifndef FRAME_TIMEOUT_EN
  // TIMEOUT only has meaning when the watchdog is built in.
  assign bus.timeout = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      scan_id               <= '0;
      settle_cnt            <= '0;
      dirty                 <= '1;
      for (int i = 0; i < NUM_MATERIALS; i++) mat_table[i] <= '0;
      bus.l2_write_enable   <= 1'b0;
      bus.l2_write_id       <= '0;
      bus.l2_write_material <= '0;
      bus.l2_flush_to_l1    <= 1'b0;
      bus.render_start      <= 1'b0;
      bus.camera_origin     <= '0;
      bus.camera_front      <= '0;
      bus.camera_left       <= '0;
      bus.camera_up         <= '0;
      bus.busy              <= 1'b0;
      bus.frame_done        <= 1'b0;
      bus.pixel_count       <= '0;
      bus.mat_wr_drop       <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      bus.timeout           <= 1'b0;
      wd_cnt                <= '0;
`endif
    end else begin
      bus.l2_write_enable <= 1'b0;
      bus.l2_flush_to_l1  <= 1'b0;
      bus.render_start    <= 1'b0;
      bus.frame_done      <= 1'b0;
      bus.mat_wr_drop     <= 1'b0;

      if (state != S_IDLE && bus.abort) begin
        state    <= S_IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              state                 <= S_LOAD;
              bus.busy              <= 1'b1;
              scan_id               <= '0;
              bus.l2_write_id       <= '0;
              bus.l2_write_material <= mat_table[0];
              bus.l2_write_enable   <= dirty[0];
              dirty[0]              <= 1'b0;
              bus.camera_origin     <= bus.cam_origin_in;
              bus.camera_front      <= bus.cam_front_in;
              bus.camera_left       <= bus.cam_left_in;
              bus.camera_up         <= bus.cam_up_in;
              bus.pixel_count       <= '0;
`ifdef FRAME_TIMEOUT_EN
              bus.timeout           <= 1'b0;
`endif
            end
          end
          S_LOAD: begin
            if (scan_id == LAST_ID) begin
              state              <= S_FLUSH;
              bus.l2_flush_to_l1 <= 1'b1;
            end else begin
              scan_id               <= next_id;
              bus.l2_write_id       <= next_id;
              bus.l2_write_material <= mat_table[next_id];
              bus.l2_write_enable   <= dirty[next_id];
              dirty[next_id]        <= 1'b0;
            end
          end
          S_FLUSH: begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state            <= S_START;
              bus.render_start <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 16'd1;
            end
          end
          S_START: begin
            state <= S_RUN;
`ifdef FRAME_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
          S_RUN: begin
            if (bus.core_output_valid) begin
              if (bus.pixel_count < PIX_TOTAL) bus.pixel_count <= bus.pixel_count + 20'd1;
              if (bus.pixel_count == PIX_TOTAL - 20'd1) begin
                state          <= S_DONE;
                bus.frame_done <= 1'b1;
              end
`ifdef FRAME_TIMEOUT_EN
              wd_cnt <= '0;
            end else if (wd_cnt == 32'(TIMEOUT - 1)) begin
              state          <= S_DONE;
              bus.frame_done <= 1'b1;
              bus.timeout    <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 32'd1;
`endif
            end
          end
          default: begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end

      // Host write comes last so a same-cycle write to entry 0 keeps its dirty bit for the next frame.
      if (bus.mat_wr_en) begin
        if (state == S_IDLE && {1'b0, bus.mat_wr_id} < NUM_IDS) begin
          mat_table[bus.mat_wr_id] <= bus.mat_wr_data;
          dirty[bus.mat_wr_id]     <= 1'b1;
        end else begin
          bus.mat_wr_drop <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_render_frame_ctrl.sv
// Directed bench for render_frame_ctrl with IMG_W=4, IMG_H=2, TIMEOUT=16.
module tb_render_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [288:0] model_tab [8];

  render_frame_ctrl_if bus ();

  render_frame_ctrl #(
    .IMG_W(4), .IMG_H(2), .NUM_MATERIALS(8), .FLUSH_WAIT(4), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [288:0] mk_mat(input logic [31:0] k);
    return {1'b1, {9{k}}};
  endfunction

  function automatic logic [95:0] mk_vec(input logic [31:0] k);
    return {k + 32'h0300_0000, k + 32'h0200_0000, k + 32'h0100_0000};
  endfunction

  // Start pulse accepted at edge 0, then checks scan (cycles 1..8), flush (9), settle (10..13), render_start (14).
  task automatic start_frame(input logic [7:0] exp_en, input logic [31:0] cam_seed);
    bus.cam_origin_in = mk_vec(cam_seed);
    bus.cam_front_in  = mk_vec(cam_seed + 32'h10);
    bus.cam_left_in   = mk_vec(cam_seed + 32'h20);
    bus.cam_up_in     = mk_vec(cam_seed + 32'h30);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("scan_id", bus.l2_write_id, i);
      chk("scan_en", bus.l2_write_enable, exp_en[i]);
      chk("scan_mat", bus.l2_write_material, model_tab[i]);
      chk("scan_flush", bus.l2_flush_to_l1, 1'b0);
      tick();
    end
    chk("flush", bus.l2_flush_to_l1, 1'b1);
    chk("flush_we", bus.l2_write_enable, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("settle_strobe", {bus.l2_flush_to_l1, bus.render_start, bus.l2_write_enable}, 3'b000);
      chk("settle_busy", bus.busy, 1'b1);
      tick();
    end
    chk("render_start", bus.render_start, 1'b1);
    chk("cam_origin", bus.camera_origin, mk_vec(cam_seed));
    chk("cam_up", bus.camera_up, mk_vec(cam_seed + 32'h30));
    tick();
    chk("render_start_end", bus.render_start, 1'b0);
  endtask

  task automatic feed(input int n, input int base);
    bus.core_output_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      chk("pixel_count", bus.pixel_count, base + k + 1);
    end
    bus.core_output_valid = 1'b0;
  endtask

  task automatic finish_frame(input int exp_count);
    chk("frame_done", bus.frame_done, 1'b1);
    chk("done_count", bus.pixel_count, exp_count);
    tick();
    chk("done_pulse_end", bus.frame_done, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("count_hold", bus.pixel_count, exp_count);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mat_wr_en = 1'b0;
    bus.mat_wr_id = '0;
    bus.mat_wr_data = '0;
    bus.cam_origin_in = '0;
    bus.cam_front_in = '0;
    bus.cam_left_in = '0;
    bus.cam_up_in = '0;
    bus.core_output_valid = 1'b0;
    for (int i = 0; i < 8; i++) model_tab[i] = '0;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_count", bus.pixel_count, 20'd0);
    chk("rst_strobes", {bus.l2_write_enable, bus.l2_flush_to_l1, bus.render_start, bus.frame_done}, 4'b0);
    chk("rst_cam", bus.camera_origin, 96'd0);
    chk("rst_timeout", bus.timeout, 1'b0);

    // Frame 1: whole table dirty after reset.
    start_frame(8'hFF, 32'h0100_0000);
    feed(8, 0);
    finish_frame(8);

    // Frame 2: only entry 5 rewritten.
    bus.mat_wr_en = 1'b1;
    bus.mat_wr_id = 3'd5;
    bus.mat_wr_data = mk_mat(32'hA5A5_0005);
    tick();
    bus.mat_wr_en = 1'b0;
    model_tab[5] = mk_mat(32'hA5A5_0005);
    chk("idle_wr_drop", bus.mat_wr_drop, 1'b0);
    start_frame(8'h20, 32'h0200_0000);
    feed(3, 0);
    // Host write while busy is rejected.
    bus.mat_wr_en = 1'b1;
    bus.mat_wr_id = 3'd2;
    bus.mat_wr_data = mk_mat(32'hDEAD_0002);
    tick();
    bus.mat_wr_en = 1'b0;
    chk("run_wr_drop", bus.mat_wr_drop, 1'b1);
    tick();
    chk("wr_drop_pulse", bus.mat_wr_drop, 1'b0);
    // start while running is ignored.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("run_start_count", bus.pixel_count, 20'd3);
    chk("run_start_busy", bus.busy, 1'b1);
    feed(5, 3);
    finish_frame(8);

    // Frame 3: nothing dirty, entry 2 still old contents.
    start_frame(8'h00, 32'h0300_0000);
    feed(8, 0);
    finish_frame(8);

    // Frame 4: abort during settle.
    bus.cam_origin_in = mk_vec(32'h0400_0000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_count", bus.pixel_count, 20'd0);
    chk("abort_cam", bus.camera_origin, mk_vec(32'h0400_0000));
    for (int i = 0; i < 12; i++) begin
      chk("abort_quiet", {bus.render_start, bus.frame_done}, 2'b00);
      tick();
    end
    start_frame(8'h00, 32'h0500_0000);
    feed(8, 0);
    finish_frame(8);

    // start with abort in the same IDLE cycle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", bus.busy, 1'b0);
    tick();
    chk("start_abort_busy2", bus.busy, 1'b0);

    // Stalled frame: 3 pixels then silence.
    start_frame(8'h00, 32'h0600_0000);
    feed(3, 0);
`ifdef FRAME_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("wd_not_yet", {bus.frame_done, bus.timeout}, 2'b00);
    end
    tick();
    chk("wd_timeout", bus.timeout, 1'b1);
    chk("wd_done", bus.frame_done, 1'b1);
    chk("wd_count", bus.pixel_count, 20'd3);
    tick();
    chk("wd_sticky", bus.timeout, 1'b1);
    chk("wd_idle", bus.busy, 1'b0);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("stall_busy", bus.busy, 1'b1);
    chk("stall_flags", {bus.frame_done, bus.timeout}, 2'b00);
    chk("stall_count", bus.pixel_count, 20'd3);
`endif

    // Reset with a frame possibly in flight restores the cold state.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model_tab[i] = '0;
    chk("rst2_busy", bus.busy, 1'b0);
    chk("rst2_count", bus.pixel_count, 20'd0);
    chk("rst2_cam", bus.camera_front, 96'd0);
    chk("rst2_timeout", bus.timeout, 1'b0);
    start_frame(8'hFF, 32'h0700_0000);
    feed(8, 0);
    finish_frame(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
